// File: rtl/reset_release_sequencer.sv
// Releases N_STAGES per-subsystem resets in order with hold time, stage spacing and a ready handshake.
// Define RST_SEQ_TIMEOUT_EN to add the per-stage ready timeout and sticky timeout_err flag.
module reset_release_sequencer #(
  parameter int unsigned N_STAGES    = 4,
  parameter int unsigned HOLD_MIN    = 16,
  parameter int unsigned STAGE_DELAY = 256,
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic                user_clk,
  input  logic                sys_clk_rst_sync,
  input  logic                idelay_rdy,
  input  logic                soft_rst_req,
  input  logic [N_STAGES-1:0] stage_ready,
  output logic [N_STAGES-1:0] stage_rst,
  output logic                seq_done,
  output logic [1:0]          seq_state,
  output logic [3:0]          stage_idx,
  output logic                timeout_err,
  output logic [15:0]         rst_count
);

  localparam int unsigned HOLD_W   = $clog2(HOLD_MIN + 1);
  localparam int unsigned DLY_W    = $clog2(STAGE_DELAY + 1);
  localparam logic [3:0]  LAST_IDX = 4'(N_STAGES - 1);

  if (N_STAGES < 1 || N_STAGES > 16 || HOLD_MIN < 1 || STAGE_DELAY < 1 ||
      SYNC_STAGES < 2 || TIMEOUT < 1) begin : g_param_check
    $error("reset_release_sequencer: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_HOLD     = 2'd0,
    S_WAIT_RDY = 2'd1,
    S_RELEASE  = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [N_STAGES-1:0]    stage_rst_q;
  logic                   seq_done_q;
  logic [3:0]             stage_idx_q;
  logic [15:0]            rst_count_q;
  logic [HOLD_W-1:0]      hold_cnt_q;
  logic [DLY_W-1:0]       delay_cnt_q;

  logic        rdy_s;
  logic [15:0] ready_ext;
  logic [15:0] rel_mask;
  logic [3:0]  next_idx;
  logic        cur_ready;
  logic        delay_done;
  logic        to_expired;
  logic        advance;
  logic        reseq;

  assign rdy_s      = sync_q[SYNC_STAGES-1];
  assign ready_ext  = 16'(stage_ready);
  assign cur_ready  = ready_ext[stage_idx_q];
  assign next_idx   = stage_idx_q + 4'd1;
  assign rel_mask   = 16'd1 << next_idx;
  // Delay counter saturates one past STAGE_DELAY-1 so "expired on an earlier edge" is visible.
  assign delay_done = delay_cnt_q >= DLY_W'(STAGE_DELAY - 1);
  assign advance    = delay_done && (cur_ready || to_expired);
  assign reseq      = soft_rst_req ||
                      (!rdy_s && (state_q == S_RELEASE || state_q == S_DONE));

`ifdef RST_SEQ_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            timeout_err_q;

  // Timeout window opens on the edge after the stage delay expired.
  assign to_expired  = (delay_cnt_q == DLY_W'(STAGE_DELAY)) && !cur_ready &&
                       (to_cnt_q == TO_W'(TIMEOUT - 1));
  assign timeout_err = timeout_err_q;
`else
  assign to_expired  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge user_clk) begin
    if (sys_clk_rst_sync) begin
      state_q     <= S_HOLD;
      sync_q      <= '0;
      stage_rst_q <= '1;
      seq_done_q  <= 1'b0;
      stage_idx_q <= 4'd0;
      rst_count_q <= 16'd0;
      hold_cnt_q  <= '0;
      delay_cnt_q <= '0;
`ifdef RST_SEQ_TIMEOUT_EN
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], idelay_rdy};
      if (reseq) begin
        state_q     <= S_HOLD;
        stage_rst_q <= '1;
        seq_done_q  <= 1'b0;
        stage_idx_q <= 4'd0;
        hold_cnt_q  <= '0;
        delay_cnt_q <= '0;
`ifdef RST_SEQ_TIMEOUT_EN
        to_cnt_q    <= '0;
`endif
        if (rst_count_q != 16'hFFFF) rst_count_q <= rst_count_q + 16'd1;
      end else begin
        case (state_q)
          S_HOLD: begin
            stage_rst_q <= '1;
            if (hold_cnt_q == HOLD_W'(HOLD_MIN - 1)) state_q <= S_WAIT_RDY;
            else hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
          S_WAIT_RDY: begin
            if (rdy_s) begin
              state_q        <= S_RELEASE;
              stage_idx_q    <= 4'd0;
              stage_rst_q[0] <= 1'b0;
              delay_cnt_q    <= '0;
`ifdef RST_SEQ_TIMEOUT_EN
              to_cnt_q       <= '0;
`endif
            end
          end
          S_RELEASE: begin
            if (delay_cnt_q != DLY_W'(STAGE_DELAY)) delay_cnt_q <= delay_cnt_q + DLY_W'(1);
`ifdef RST_SEQ_TIMEOUT_EN
            else if (!cur_ready) to_cnt_q <= to_cnt_q + TO_W'(1);
`endif
            if (advance) begin
              delay_cnt_q <= '0;
`ifdef RST_SEQ_TIMEOUT_EN
              to_cnt_q    <= '0;
              if (to_expired) timeout_err_q <= 1'b1;
`endif
              if (stage_idx_q == LAST_IDX) begin
                state_q    <= S_DONE;
                seq_done_q <= 1'b1;
              end else begin
                stage_idx_q <= next_idx;
                stage_rst_q <= stage_rst_q & ~rel_mask[N_STAGES-1:0];
              end
            end
          end
          S_DONE: seq_done_q <= 1'b1;
          default: state_q <= S_HOLD;
        endcase
      end
    end
  end

  assign stage_rst = stage_rst_q;
  assign seq_done  = seq_done_q;
  assign seq_state = state_q;
  assign stage_idx = stage_idx_q;
  assign rst_count = rst_count_q;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Scoreboard bench for reset_release_sequencer: stimulus queues per-cycle expected outputs, a monitor checks them.
module tb_reset_release_sequencer;

  logic        user_clk = 1'b0;
  logic        sys_clk_rst_sync;
  logic        idelay_rdy;
  logic        soft_rst_req;
  logic [3:0]  stage_ready;
  logic [3:0]  stage_rst;
  logic        seq_done;
  logic [1:0]  seq_state;
  logic [3:0]  stage_idx;
  logic        timeout_err;
  logic [15:0] rst_count;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  rst;
    logic [1:0]  st;
    logic [3:0]  idx;
    logic        done;
    logic        terr;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] cyc = 32'd0;
  int          checks = 0;
  int          failures = 0;

`ifdef RST_SEQ_TIMEOUT_EN
  localparam logic TE = 1'b1;
`else
  localparam logic TE = 1'b0;
`endif

  reset_release_sequencer #(
    .N_STAGES(4), .HOLD_MIN(4), .STAGE_DELAY(8), .SYNC_STAGES(2), .TIMEOUT(32)
  ) dut (
    .user_clk        (user_clk),
    .sys_clk_rst_sync(sys_clk_rst_sync),
    .idelay_rdy      (idelay_rdy),
    .soft_rst_req    (soft_rst_req),
    .stage_ready     (stage_ready),
    .stage_rst       (stage_rst),
    .seq_done        (seq_done),
    .seq_state       (seq_state),
    .stage_idx       (stage_idx),
    .timeout_err     (timeout_err),
    .rst_count       (rst_count)
  );

  always #5 user_clk = ~user_clk;
  always @(posedge user_clk) cyc <= cyc + 32'd1;

  task automatic exp_at(input int c, input logic [3:0] r, input logic [1:0] s, input logic [3:0] i,
                        input logic d, input logic t, input logic [15:0] n);
    exp_t e;
    e.cyc = 32'(c); e.rst = r; e.st = s; e.idx = i; e.done = d; e.terr = t; e.cnt = n;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < 32'(c)) @(negedge user_clk);
  endtask

  // Monitor: outputs are registered, so each cycle's snapshot is read on the falling edge.
  always @(negedge user_clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (mon_e.cyc != cyc) begin
        failures++;
        $display("FAIL cyc%0d: expectation reached at cycle %0d, required at cycle %0d", mon_e.cyc, cyc, mon_e.cyc);
      end else if ({stage_rst, seq_state, stage_idx, seq_done, timeout_err, rst_count} !==
                   {mon_e.rst, mon_e.st, mon_e.idx, mon_e.done, mon_e.terr, mon_e.cnt}) begin
        failures++;
        $display("FAIL cyc%0d: got rst=%b st=%0d idx=%0d done=%b terr=%b cnt=%0d, required rst=%b st=%0d idx=%0d done=%b terr=%b cnt=%0d",
                 mon_e.cyc, stage_rst, seq_state, stage_idx, seq_done, timeout_err, rst_count,
                 mon_e.rst, mon_e.st, mon_e.idx, mon_e.done, mon_e.terr, mon_e.cnt);
      end
    end
  end

  initial begin
    sys_clk_rst_sync = 1'b1;
    idelay_rdy       = 1'b1;
    soft_rst_req     = 1'b0;
    stage_ready      = 4'hF;

    // Reset, hold, then releases 8 cycles apart and DONE.
    for (int c = 1; c <= 4; c++) exp_at(c, 4'hF, 2'd0, 4'd0, 1'b0, 1'b0, 16'd0);
    exp_at(6,  4'hF, 2'd0, 4'd0, 1'b0, 1'b0, 16'd0);
    exp_at(7,  4'hF, 2'd1, 4'd0, 1'b0, 1'b0, 16'd0);
    exp_at(8,  4'hE, 2'd2, 4'd0, 1'b0, 1'b0, 16'd0);
    exp_at(15, 4'hE, 2'd2, 4'd0, 1'b0, 1'b0, 16'd0);
    exp_at(16, 4'hC, 2'd2, 4'd1, 1'b0, 1'b0, 16'd0);
    exp_at(23, 4'hC, 2'd2, 4'd1, 1'b0, 1'b0, 16'd0);
    exp_at(24, 4'h8, 2'd2, 4'd2, 1'b0, 1'b0, 16'd0);
    exp_at(31, 4'h8, 2'd2, 4'd2, 1'b0, 1'b0, 16'd0);
    exp_at(32, 4'h0, 2'd2, 4'd3, 1'b0, 1'b0, 16'd0);
    exp_at(39, 4'h0, 2'd2, 4'd3, 1'b0, 1'b0, 16'd0);
    exp_at(40, 4'h0, 2'd3, 4'd3, 1'b1, 1'b0, 16'd0);
    exp_at(42, 4'h0, 2'd3, 4'd3, 1'b1, 1'b0, 16'd0);
    wait_cyc(3);
    sys_clk_rst_sync = 1'b0;

    // Soft request in DONE; stage 1 ready held low 20 cycles past its delay.
    wait_cyc(42);
    soft_rst_req = 1'b1;
    stage_ready  = 4'b1101;
    exp_at(43, 4'hF, 2'd0, 4'd0, 1'b0, 1'b0, 16'd1);
    exp_at(46, 4'hF, 2'd0, 4'd0, 1'b0, 1'b0, 16'd1);
    exp_at(47, 4'hF, 2'd1, 4'd0, 1'b0, 1'b0, 16'd1);
    exp_at(48, 4'hE, 2'd2, 4'd0, 1'b0, 1'b0, 16'd1);
    exp_at(56, 4'hC, 2'd2, 4'd1, 1'b0, 1'b0, 16'd1);
    exp_at(64, 4'hC, 2'd2, 4'd1, 1'b0, 1'b0, 16'd1);
    exp_at(75, 4'hC, 2'd2, 4'd1, 1'b0, 1'b0, 16'd1);
    exp_at(83, 4'hC, 2'd2, 4'd1, 1'b0, 1'b0, 16'd1);
    exp_at(84, 4'h8, 2'd2, 4'd2, 1'b0, 1'b0, 16'd1);
    wait_cyc(43);
    soft_rst_req = 1'b0;

    // Stage 1 ready rises, stage 2 never becomes ready.
    wait_cyc(83);
    stage_ready = 4'b1011;
    exp_at(91,  4'h8, 2'd2, 4'd2, 1'b0, 1'b0, 16'd1);
    exp_at(92,  4'h8, 2'd2, 4'd2, 1'b0, 1'b0, 16'd1);
    exp_at(123, 4'h8, 2'd2, 4'd2, 1'b0, 1'b0, 16'd1);
`ifdef RST_SEQ_TIMEOUT_EN
    exp_at(124, 4'h0, 2'd2, 4'd3, 1'b0, 1'b1, 16'd1);
    exp_at(131, 4'h0, 2'd2, 4'd3, 1'b0, 1'b1, 16'd1);
    exp_at(132, 4'h0, 2'd3, 4'd3, 1'b1, 1'b1, 16'd1);
    exp_at(140, 4'h0, 2'd3, 4'd3, 1'b1, 1'b1, 16'd1);
`else
    exp_at(124, 4'h8, 2'd2, 4'd2, 1'b0, 1'b0, 16'd1);
    exp_at(140, 4'h8, 2'd2, 4'd2, 1'b0, 1'b0, 16'd1);
`endif

    // Soft request, then another during stage 1 delay.
    wait_cyc(141);
    soft_rst_req = 1'b1;
    stage_ready  = 4'hF;
    exp_at(142, 4'hF, 2'd0, 4'd0, 1'b0, TE, 16'd2);
    exp_at(146, 4'hF, 2'd1, 4'd0, 1'b0, TE, 16'd2);
    exp_at(147, 4'hE, 2'd2, 4'd0, 1'b0, TE, 16'd2);
    exp_at(155, 4'hC, 2'd2, 4'd1, 1'b0, TE, 16'd2);
    exp_at(158, 4'hC, 2'd2, 4'd1, 1'b0, TE, 16'd2);
    wait_cyc(142);
    soft_rst_req = 1'b0;
    wait_cyc(158);
    soft_rst_req = 1'b1;
    exp_at(159, 4'hF, 2'd0, 4'd0, 1'b0, TE, 16'd3);
    exp_at(163, 4'hF, 2'd1, 4'd0, 1'b0, TE, 16'd3);
    exp_at(164, 4'hE, 2'd2, 4'd0, 1'b0, TE, 16'd3);
    exp_at(172, 4'hC, 2'd2, 4'd1, 1'b0, TE, 16'd3);
    exp_at(180, 4'h8, 2'd2, 4'd2, 1'b0, TE, 16'd3);
    exp_at(188, 4'h0, 2'd2, 4'd3, 1'b0, TE, 16'd3);
    exp_at(195, 4'h0, 2'd2, 4'd3, 1'b0, TE, 16'd3);
    exp_at(196, 4'h0, 2'd3, 4'd3, 1'b1, TE, 16'd3);
    exp_at(198, 4'h0, 2'd3, 4'd3, 1'b1, TE, 16'd3);
    wait_cyc(159);
    soft_rst_req = 1'b0;

    // Loss of idelay_rdy in DONE, recovery from WAIT_RDY.
    wait_cyc(198);
    idelay_rdy = 1'b0;
    exp_at(199, 4'h0, 2'd3, 4'd3, 1'b1, TE, 16'd3);
    exp_at(200, 4'h0, 2'd3, 4'd3, 1'b1, TE, 16'd3);
    exp_at(201, 4'hF, 2'd0, 4'd0, 1'b0, TE, 16'd4);
    exp_at(204, 4'hF, 2'd0, 4'd0, 1'b0, TE, 16'd4);
    exp_at(205, 4'hF, 2'd1, 4'd0, 1'b0, TE, 16'd4);
    exp_at(215, 4'hF, 2'd1, 4'd0, 1'b0, TE, 16'd4);
    wait_cyc(215);
    idelay_rdy = 1'b1;
    exp_at(217, 4'hF, 2'd1, 4'd0, 1'b0, TE, 16'd4);
    exp_at(218, 4'hE, 2'd2, 4'd0, 1'b0, TE, 16'd4);
    exp_at(222, 4'hE, 2'd2, 4'd0, 1'b0, TE, 16'd4);

    // Synchronous reset mid-RELEASE clears everything including sticky/count state.
    wait_cyc(222);
    sys_clk_rst_sync = 1'b1;
    exp_at(223, 4'hF, 2'd0, 4'd0, 1'b0, 1'b0, 16'd0);
    exp_at(224, 4'hF, 2'd0, 4'd0, 1'b0, 1'b0, 16'd0);
    exp_at(227, 4'hF, 2'd0, 4'd0, 1'b0, 1'b0, 16'd0);
    exp_at(228, 4'hF, 2'd1, 4'd0, 1'b0, 1'b0, 16'd0);
    exp_at(229, 4'hE, 2'd2, 4'd0, 1'b0, 1'b0, 16'd0);
    wait_cyc(224);
    sys_clk_rst_sync = 1'b0;

    // Continuous soft requests drive rst_count to saturation while pinned in HOLD.
    wait_cyc(230);
    soft_rst_req = 1'b1;
    exp_at(231,   4'hF, 2'd0, 4'd0, 1'b0, 1'b0, 16'd1);
    exp_at(232,   4'hF, 2'd0, 4'd0, 1'b0, 1'b0, 16'd2);
    exp_at(1230,  4'hF, 2'd0, 4'd0, 1'b0, 1'b0, 16'd1000);
    exp_at(65764, 4'hF, 2'd0, 4'd0, 1'b0, 1'b0, 16'd65534);
    exp_at(65765, 4'hF, 2'd0, 4'd0, 1'b0, 1'b0, 16'hFFFF);
    exp_at(65770, 4'hF, 2'd0, 4'd0, 1'b0, 1'b0, 16'hFFFF);
    wait_cyc(65770);
    soft_rst_req = 1'b0;
    exp_at(65773, 4'hF, 2'd0, 4'd0, 1'b0, 1'b0, 16'hFFFF);
    exp_at(65774, 4'hF, 2'd1, 4'd0, 1'b0, 1'b0, 16'hFFFF);
    exp_at(65775, 4'hE, 2'd2, 4'd0, 1'b0, 1'b0, 16'hFFFF);
    wait_cyc(65776);
    soft_rst_req = 1'b1;
    exp_at(65777, 4'hF, 2'd0, 4'd0, 1'b0, 1'b0, 16'hFFFF);
    wait_cyc(65777);
    soft_rst_req = 1'b0;

    wait_cyc(65780);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
